tea_stream_feeder: RTL and testbench

Upstream feeder and flow-control wrapper for the TEA encryption pipeline. Accepts 32-bit plaintext words on a valid/ready stream and assembles them into 64-bit blocks. Loads a 128-bit key by word writes and drives plaintext and key into the pipeline. Because the pipeline has no valid or stall path, the feeder tracks in-flight blocks with a delay line and credit counter, then captures ciphertext into an output FIFO that supports backpressure.

---
 rtl/tea_pkg.sv | 38 +++
 rtl/tea_out_fifo.sv | 83 ++++++++
 rtl/tea_stream_feeder.sv | 165 ++++++++++++++++
 tb/tb_tea_stream_feeder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared definitions for the TEA stream feeder.
// Provides the TEA round constant, the block, key and word widths, the
// word-pairing FSM state type, and a helper that merges one 32-bit key word
// write into a 128-bit key.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E37_79B9;
    localparam int          BLOCK_W   = 64;
    localparam int          KEY_W     = 128;
    localparam int          WORD_W    = 32;

    typedef enum logic [1:0] {
        S_W0  = 2'd0,   // waiting for the first word of a block
        S_W1  = 2'd1,   // first word held, waiting for the second
        S_PAD = 2'd2    // odd final word parked until a credit frees up
    } feed_state_e;

    // Word 0 is the most significant word of the key.
    function automatic logic [KEY_W-1:0] key_merge(
        input logic [KEY_W-1:0]  key_in,
        input logic              wr,
        input logic [1:0]        idx,
        input logic [WORD_W-1:0] word
    );
        logic [KEY_W-1:0] key_out;
        key_out = key_in;
        if (wr) begin
            case (idx)
                2'd0:    key_out[127:96] = word;
                2'd1:    key_out[95:64]  = word;
                2'd2:    key_out[63:32]  = word;
                default: key_out[31:0]   = word;
            endcase
        end
        return key_out;
    endfunction

endpackage

// File: rtl/tea_out_fifo.sv
// First-word-fall-through register FIFO for ciphertext blocks.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en, wr_data       write strobe and data
//   rd_en                consume the head entry (ignored while empty)
//   rd_valid, rd_data    head entry is valid / head entry value
//   count                number of stored entries
module tea_out_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        pop      = rd_en && (count_q != '0);
        // A full FIFO still takes a write when the head leaves in the same cycle.
        push     = wr_en && ((count_q != CNT_W'(DEPTH)) || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/tea_stream_feeder.sv
// Feeder and flow-control wrapper in front of a TEA encryption pipeline.
// Pairs 32-bit plaintext words into 64-bit blocks (padding an odd final word
// with zero), drives block and key into the pipeline, tracks in-flight blocks
// with a delay line and credit counter, and buffers the ciphertext in an
// output FIFO with valid/ready backpressure.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   key_wr, key_idx, key_word      key word writes (idx 0 = key[127:96])
//   in_valid/in_ready/in_data      plaintext word stream, in_last = final word
//   plaintext, key                 block and key driven to the pipeline
//   ciphertext                     pipeline result
//   out_valid/out_ready/out_data   ciphertext block stream
module tea_stream_feeder
    import tea_pkg::*;
#(
    parameter int ROUNDS     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_wr,
    input  logic [1:0]          key_idx,
    input  logic [WORD_W-1:0]   key_word,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_last,
    output logic [BLOCK_W-1:0]  plaintext,
    output logic [KEY_W-1:0]    key,
    input  logic [BLOCK_W-1:0]  ciphertext,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  out_data
);

    localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    feed_state_e         state_q, state_d;
    logic [WORD_W-1:0]   v0_q, v0_d;
    logic [BLOCK_W-1:0]  plaintext_q, plaintext_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [KEY_W-1:0]    wkey_q, wkey_d;
    logic                issue_q, issue_d;
    logic [ROUNDS:0]     dl_q, dl_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [BLOCK_W-1:0]  issue_blk;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      occupancy;
    logic                credit_ok;
    logic                tap;

    // A block may only be issued if a FIFO slot is reserved for it. Only
    // registered counts are used, so a pop this cycle frees its credit next cycle.
    always_comb begin
        occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
        credit_ok = (occupancy < CREDIT_MAX);
    end

    // Word pairing
    always_comb begin
        state_d   = state_q;
        v0_d      = v0_q;
        issue_d   = 1'b0;
        issue_blk = '0;
        in_ready  = 1'b0;
        case (state_q)
            S_W0: begin
                // A first word is always taken; an odd final word without a
                // credit waits in S_PAD instead of stalling the input.
                in_ready = 1'b1;
                if (in_valid) begin
                    v0_d = in_data;
                    if (in_last) begin
                        if (credit_ok) begin
                            issue_d   = 1'b1;
                            issue_blk = {in_data, 32'h0};
                        end else begin
                            state_d = S_PAD;
                        end
                    end else begin
                        state_d = S_W1;
                    end
                end
            end
            S_W1: begin
                in_ready = credit_ok;
                if (in_valid && credit_ok) begin
                    issue_d   = 1'b1;
                    issue_blk = {v0_q, in_data};
                    state_d   = S_W0;
                end
            end
            S_PAD: begin
                if (credit_ok) begin
                    issue_d   = 1'b1;
                    issue_blk = {v0_q, 32'h0};
                    state_d   = S_W0;
                end
            end
            default: begin
                state_d = S_W0;
            end
        endcase
    end

    // Issue: a key write in the issue cycle already applies to that block
    always_comb begin
        wkey_d      = key_merge(wkey_q, key_wr, key_idx, key_word);
        plaintext_d = issue_d ? issue_blk : plaintext_q;
        key_d       = issue_d ? wkey_d : key_q;
    end

    // Delay line matching the pipeline latency; its tap marks valid ciphertext
    always_comb begin
        dl_d = {dl_q[ROUNDS-1:0], issue_q};
        tap  = dl_q[ROUNDS];
        case ({issue_d, tap})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_W0;
            v0_q        <= '0;
            plaintext_q <= '0;
            key_q       <= '0;
            wkey_q      <= '0;
            issue_q     <= 1'b0;
            dl_q        <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            v0_q        <= v0_d;
            plaintext_q <= plaintext_d;
            key_q       <= key_d;
            wkey_q      <= wkey_d;
            issue_q     <= issue_d;
            dl_q        <= dl_d;
            inflight_q  <= inflight_d;
        end
    end

    assign plaintext = plaintext_q;
    assign key       = key_q;

    // Output buffer
    tea_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BLOCK_W)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (tap),
        .wr_data  (ciphertext),
        .rd_en    (out_ready),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_tea_stream_feeder.sv
`timescale 1ns/1ps
module tb_tea_stream_feeder;
    import tea_pkg::*;

    localparam int ROUNDS     = 1;
    localparam int FIFO_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_wr = 1'b0;
    logic [1:0]   key_idx = 2'd0;
    logic [31:0]  key_word = 32'h0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'h0;
    logic         in_last = 1'b0;
    logic [63:0]  plaintext;
    logic [127:0] key;
    logic [63:0]  ciphertext;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [63:0]  out_data;

    always #5 clk = ~clk;

    tea_stream_feeder #(.ROUNDS(ROUNDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr(key_wr), .key_idx(key_idx), .key_word(key_word),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .plaintext(plaintext), .key(key), .ciphertext(ciphertext),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // TEA pipeline: input register followed by one register per round; key travels with data.
    function automatic logic [63:0] tea_stage(input logic [63:0] v, input logic [127:0] k, input logic [31:0] sum);
        logic [31:0] y, z;
        y = v[63:32];
        z = v[31:0];
        y = y + (((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]));
        z = z + (((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]));
        return {y, z};
    endfunction

    logic [63:0]  pipe_v [ROUNDS+1];
    logic [127:0] pipe_k [ROUNDS+1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ROUNDS; i++) begin
                pipe_v[i] <= '0;
                pipe_k[i] <= '0;
            end
        end else begin
            pipe_v[0] <= plaintext;
            pipe_k[0] <= key;
            for (int r = 1; r <= ROUNDS; r++) begin
                pipe_v[r] <= tea_stage(pipe_v[r-1], pipe_k[r-1], 32'(TEA_DELTA * r));
                pipe_k[r] <= pipe_k[r-1];
            end
        end
    end
    assign ciphertext = pipe_v[ROUNDS];

    // Reference: plain TEA encryption over ROUNDS cycles.
    function automatic logic [63:0] tea_ref(input logic [63:0] pt, input logic [127:0] k);
        logic [31:0] y, z, sum;
        y = pt[63:32];
        z = pt[31:0];
        sum = 32'h0;
        for (int r = 0; r < ROUNDS; r++) begin
            sum = sum + TEA_DELTA;
            y = y + (((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]));
            z = z + (((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]));
        end
        return {y, z};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: pairs accepted words into blocks, predicts ciphertext in order.
    logic         pend = 1'b0;
    logic [31:0]  m_v0 = 32'h0;
    logic [127:0] m_key = '0;
    logic [127:0] k_eff;
    logic [63:0]  exp_q [$];
    int           blocks_in = 0;
    int           blocks_out = 0;
    logic         prev_stall = 1'b0;
    logic [63:0]  prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            k_eff = m_key;
            if (key_wr) k_eff[96 - 32*int'(key_idx) +: 32] = key_word;
            if (in_valid && in_ready) begin
                if (pend) begin
                    exp_q.push_back(tea_ref({m_v0, in_data}, k_eff));
                    pend = 1'b0;
                    blocks_in++;
                end else if (in_last) begin
                    exp_q.push_back(tea_ref({in_data, 32'h0}, k_eff));
                    blocks_in++;
                end else begin
                    pend = 1'b1;
                    m_v0 = in_data;
                end
            end
            m_key = k_eff;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                blocks_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_output: actual %h, required no block", out_data);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_order: actual %h, required %h", out_data, e);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual in_ready=0 for %0d cycles, required acceptance", n);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic write_key(input logic [127:0] k);
        for (int j = 0; j < 4; j++) begin
            key_wr   = 1'b1;
            key_idx  = 2'(j);
            key_word = k[96 - 32*j +: 32];
            tick();
        end
        key_wr = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < bound) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [127:0] k;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic         odd;
        logic [63:0]  exp;
    } vec_t;

    vec_t        tbl [5];
    int          base;
    int          base_in;
    int          lat;
    logic [31:0] a0, a1, b0, b1;
    logic        rand_done = 1'b0;

    initial begin
        tbl[0] = '{128'h0, 32'h0, 32'h0, 1'b0, 64'h9E3779B9_DBE8D32F};
        tbl[1] = '{128'h0, 32'h0, 32'h0, 1'b1, 64'h9E3779B9_DBE8D32F};
        tbl[2] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h01234567, 32'h89ABCDEF, 1'b0,
                   tea_ref(64'h01234567_89ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF)};
        tbl[3] = '{128'hDEADBEEF_00000001_CAFEF00D_80000000, 32'hFFFFFFFF, 32'h0, 1'b1,
                   tea_ref(64'hFFFFFFFF_00000000, 128'hDEADBEEF_00000001_CAFEF00D_80000000)};
        tbl[4] = '{{4{32'hFFFFFFFF}}, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                   tea_ref(64'hFFFFFFFF_FFFFFFFF, {4{32'hFFFFFFFF}})};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_plaintext", plaintext, 0);
        check("rst_key", key, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single blocks: latency, padding, data and key at the pipeline
        for (int i = 0; i < 5; i++) begin
            write_key(tbl[i].k);
            send_word(tbl[i].w0, tbl[i].odd);
            if (!tbl[i].odd) send_word(tbl[i].w1, 1'b1);
            check($sformatf("vec%0d_plaintext", i), plaintext, {tbl[i].w0, tbl[i].odd ? 32'h0 : tbl[i].w1});
            check($sformatf("vec%0d_key", i), key, tbl[i].k);
            lat = 0;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", i), lat, ROUNDS + 2);
            check($sformatf("vec%0d_out_data", i), out_data, tbl[i].exp);
            tick();
            check($sformatf("vec%0d_popped", i), out_valid, 0);
        end

        // Backpressure: 6 blocks into a 4-deep FIFO with the output stalled
        base = blocks_out;
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            send_word($urandom, 1'b0);
            send_word($urandom, 1'b0);
        end
        send_word($urandom, 1'b0);
        for (int c = 0; c < 6; c++) begin
            check("bp_in_ready_low", in_ready, 0);
            tick();
        end
        check("bp_out_valid", out_valid, 1);
        check("bp_head", out_data, exp_q[0]);
        out_ready = 1'b1;
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b1);
        drain("bp_drain", 100);
        check("bp_count", blocks_out - base, 6);

        // Key update: block A already in flight, block B issued with the last key write
        a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
        send_word(a0, 1'b0);
        send_word(a1, 1'b0);
        in_valid = 1'b1; in_data = b0; in_last = 1'b0;
        key_wr = 1'b1; key_idx = 2'd0; key_word = 32'd1;
        tick();
        in_valid = 1'b0;
        key_idx = 2'd1; key_word = 32'd2;
        tick();
        key_idx = 2'd2; key_word = 32'd3;
        tick();
        key_idx = 2'd3; key_word = 32'd4;
        in_valid = 1'b1; in_data = b1; in_last = 1'b1;
        check("key_b_ready", in_ready, 1);
        tick();
        key_wr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("key_b_key", key, 128'h00000001_00000002_00000003_00000004);
        check("key_b_plaintext", plaintext, {b0, b1});
        drain("key_drain", 50);

        // Reset mid-operation
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            send_word($urandom, 1'b0);
            send_word($urandom, 1'b0);
        end
        repeat (4) tick();
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_plaintext", plaintext, 0);
        check("mid_rst_key", key, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        pend = 1'b0;
        m_key = '0;
        prev_stall = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        base = blocks_out;
        send_word(32'h0, 1'b0);
        send_word(32'h0, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("post_rst_data", out_data, 64'h9E3779B9_DBE8D32F);
        drain("post_rst_drain", 50);
        repeat (5) tick();
        check("post_rst_count", blocks_out - base, 1);

        // Random traffic with random output stalls
        write_key({$urandom, $urandom, $urandom, $urandom});
        base = blocks_out;
        base_in = blocks_in;
        fork
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join_none
        while (blocks_in - base_in < 100) begin
            repeat ($urandom_range(0, 2)) tick();
            send_word($urandom, ($urandom_range(0, 3) == 0));
        end
        rand_done = 1'b1;
        tick();
        out_ready = 1'b1;
        drain("rand_drain", 200);
        check("rand_count", blocks_out - base, blocks_in - base_in);
        check("rand_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
